// File: rtl/div_seq_if.sv
// Operand/result bundle for the sequential signed divider: clock enable,
// start request, operands, and the registered result with its flags.
interface div_seq_if #(
   parameter int A_width = 16,
   parameter int B_width = 16
);
   logic               ce;
   logic               start;
   logic [A_width-1:0] A;
   logic [B_width-1:0] B;
   logic               busy;
   logic               valid;
   logic [A_width-1:0] Q;
   logic [B_width-1:0] R;
   logic               div0;
   logic               ovf;

   modport master (
      output ce, start, A, B,
      input  busy, valid, Q, R, div0, ovf
   );

   modport slave (
      input  ce, start, A, B,
      output busy, valid, Q, R, div0, ovf
   );
endinterface

// File: rtl/div_seq.sv
// Sequential signed restoring divider, one quotient bit per enabled cycle.
// Define DIV_SEQ_REM_EN to compute the remainder; otherwise R is tied to 0.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on acceptance
// LOAD   | take operand magnitudes, record quotient/remainder signs
// ITER   | A_width restoring shift/subtract steps; result registered on the last
// FIX    | result presented, valid high for this cycle
module div_seq #(
   parameter int A_width = 16,
   parameter int B_width = 16
) (
   input logic       clk,
   input logic       resetn,
   div_seq_if.slave  bus
);

   localparam int CW = (A_width > 2) ? $clog2(A_width) : 1;
   localparam logic [A_width-1:0] Q_MAX = {1'b0, {(A_width-1){1'b1}}};
   localparam logic [A_width-1:0] Q_MIN = {1'b1, {(A_width-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [A_width-1:0] r_qsh;
   logic [B_width-1:0] r_bmag;
   logic [B_width:0]   r_prem;
   logic [CW-1:0]      r_cnt;
   logic               r_qsign;
   logic               r_rsign;
   logic               r_bzero;
   logic [A_width-1:0] r_quo;
   logic               r_div0;
   logic               r_ovf;

   logic [B_width:0]   w_shift;
   logic [B_width:0]   w_trial;
   logic [B_width:0]   w_prem_nxt;
   logic [A_width-1:0] w_qsh_nxt;
   logic               w_ge;
   logic               w_last;
   logic [A_width-1:0] w_quo_fix;
   logic               w_ovf_nxt;

   assign w_shift    = {r_prem[B_width-1:0], r_qsh[A_width-1]};
   assign w_ge       = ({r_prem, r_qsh[A_width-1]} >= {2'b00, r_bmag});
   assign w_trial    = w_shift - {1'b0, r_bmag};
   assign w_prem_nxt = w_ge ? w_trial : w_shift;
   assign w_qsh_nxt  = {r_qsh[A_width-2:0], w_ge};
   assign w_last     = (r_cnt == '0);

   // A positive quotient whose magnitude reaches 2^(A_width-1) only arises from MIN / -1.
   always_comb begin
      w_quo_fix = w_qsh_nxt;
      w_ovf_nxt = 1'b0;
      if (r_bzero) begin
         w_quo_fix = r_rsign ? Q_MIN : Q_MAX;
      end else if (!r_qsign && w_qsh_nxt[A_width-1]) begin
         w_quo_fix = Q_MIN;
         w_ovf_nxt = 1'b1;
      end else if (r_qsign) begin
         w_quo_fix = -w_qsh_nxt;
      end
   end

`ifdef DIV_SEQ_REM_EN
   logic [B_width-1:0] r_rem;
   logic [B_width-1:0] w_rem_fix;

   always_comb begin
      w_rem_fix = '0;
      if (!r_bzero) begin
         w_rem_fix = r_rsign ? -w_prem_nxt[B_width-1:0] : w_prem_nxt[B_width-1:0];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rem <= '0;
      end else if (bus.ce && r_state == S_ITER && w_last) begin
         r_rem <= w_rem_fix;
      end
   end

   assign bus.R = r_rem;
`else
   assign bus.R = '0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else if (bus.ce) begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_ITER;
         S_ITER:  if (w_last) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_qsh   <= '0;
         r_bmag  <= '0;
         r_prem  <= '0;
         r_cnt   <= '0;
         r_qsign <= 1'b0;
         r_rsign <= 1'b0;
         r_bzero <= 1'b0;
         r_quo   <= '0;
         r_div0  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (bus.ce) begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_qsh  <= bus.A;
                  r_bmag <= bus.B;
               end
            end
            S_LOAD: begin
               r_qsh   <= r_qsh[A_width-1] ? -r_qsh : r_qsh;
               r_bmag  <= r_bmag[B_width-1] ? -r_bmag : r_bmag;
               r_qsign <= r_qsh[A_width-1] ^ r_bmag[B_width-1];
               r_rsign <= r_qsh[A_width-1];
               r_bzero <= (r_bmag == '0);
               r_prem  <= '0;
               r_cnt   <= CW'(A_width - 1);
            end
            S_ITER: begin
               r_qsh  <= w_qsh_nxt;
               r_prem <= w_prem_nxt;
               r_cnt  <= r_cnt - 1'b1;
               if (w_last) begin
                  r_quo  <= w_quo_fix;
                  r_div0 <= r_bzero;
                  r_ovf  <= w_ovf_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy  = (r_state != S_IDLE);
   assign bus.valid = (r_state == S_FIX);
   assign bus.Q     = r_quo;
   assign bus.div0  = r_div0;
   assign bus.ovf   = r_ovf;

endmodule
